// File: rtl/alu_mc_if.sv
// rtl/alu_mc_if.sv - request/result handshake bundle for the multi-cycle ALU
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [4:0]       op_i;
    logic [WIDTH-1:0] rd_i;
    logic [WIDTH-1:0] rs_i;
    logic             kill_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] result_o;
    logic             jump_now_o;
    logic             illegal_o;

    modport master (
        output valid_i, op_i, rd_i, rs_i, kill_i, ready_i,
        input  ready_o, valid_o, result_o, jump_now_o, illegal_o
    );

    modport slave (
        input  valid_i, op_i, rd_i, rs_i, kill_i, ready_i,
        output ready_o, valid_o, result_o, jump_now_o, illegal_o
    );
endinterface

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - registered ALU with iterative unsigned multiply/divide
module alu_mc #(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input logic   clk,
    input logic   n_reset,
    alu_mc_if.slave bus
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [SW:0] WL = (SW+1)'(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t             state;
    logic [SW:0]        cnt;
    logic [WIDTH-1:0]   opa;
    logic               hi_sel;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   diff;
    logic [SW-1:0]      sh;
    logic [SW:0]        rsh;
    logic [WIDTH-1:0]   fast_result;
    logic               fast_jump;
    logic               fast_illegal;
    logic               is_iter;

    assign bus.ready_o = (state == IDLE) && (!bus.valid_o || bus.ready_i) && n_reset;
    assign is_iter     = (MUL_EN != 0) && (bus.op_i[4:2] == 3'b011);
    assign sh          = bus.rs_i[SW-1:0];
    assign rsh         = WL - {1'b0, sh};

    // MUL: acc = {partial product, remaining multiplier bits}.
    // DIV: acc = {partial remainder, dividend bits / quotient bits shifting in}.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opa} : '0);
        shifted  = acc[2*WIDTH-1:WIDTH-1];
        diff     = shifted[WIDTH-1:0] - opa;
        acc_next = {sum, acc[WIDTH-1:1]};
        if (state == DIV) begin
            if (shifted >= {1'b0, opa})
                acc_next = {diff, acc[WIDTH-2:0], 1'b1};
            else
                acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        fast_result  = '0;
        fast_jump    = 1'b0;
        fast_illegal = 1'b0;
        case (bus.op_i)
            5'd0:  fast_result = bus.rd_i + bus.rs_i;
            5'd1:  fast_result = bus.rd_i - bus.rs_i;
            5'd2:  fast_result = bus.rd_i << sh;
            5'd3:  fast_result = $signed(bus.rd_i) >>> sh;
            5'd4:  fast_result = bus.rd_i >> sh;
            5'd5:  fast_result = bus.rd_i & bus.rs_i;
            5'd6:  fast_result = bus.rd_i | bus.rs_i;
            5'd7:  fast_result = ~(bus.rd_i | bus.rs_i);
            5'd8:  fast_result = {{(WIDTH-1){1'b0}}, $signed(bus.rd_i) < $signed(bus.rs_i)};
            5'd9:  fast_result = {{(WIDTH-1){1'b0}}, bus.rd_i < bus.rs_i};
            5'd10: fast_result = bus.rd_i ^ bus.rs_i;
            // A shift by WIDTH yields zero, so amount 0 returns rd_i unchanged.
            5'd11: fast_result = (bus.rd_i << sh) | (bus.rd_i >> rsh);
            5'd16: fast_jump   = (bus.rd_i == '0);
            5'd17: fast_jump   = (bus.rd_i != '0);
            5'd18: fast_jump   = !bus.rd_i[WIDTH-1] && (bus.rd_i != '0);
            5'd19: fast_jump   = bus.rd_i[WIDTH-1];
            default: fast_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state          <= IDLE;
            cnt            <= '0;
            opa            <= '0;
            hi_sel         <= 1'b0;
            acc            <= '0;
            bus.valid_o    <= 1'b0;
            bus.result_o   <= '0;
            bus.jump_now_o <= 1'b0;
            bus.illegal_o  <= 1'b0;
        end else if (bus.kill_i) begin
            state       <= IDLE;
            cnt         <= '0;
            bus.valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.valid_i && bus.ready_o) begin
                        if (is_iter) begin
                            state       <= bus.op_i[1] ? DIV : MUL;
                            cnt         <= WL;
                            hi_sel      <= bus.op_i[0];
                            opa         <= bus.op_i[1] ? bus.rs_i : bus.rd_i;
                            acc         <= {{WIDTH{1'b0}}, bus.op_i[1] ? bus.rd_i : bus.rs_i};
                            bus.valid_o <= 1'b0;
                        end else begin
                            bus.valid_o    <= 1'b1;
                            bus.result_o   <= fast_result;
                            bus.jump_now_o <= fast_jump;
                            bus.illegal_o  <= fast_illegal;
                        end
                    end else if (bus.valid_o && bus.ready_i) begin
                        bus.valid_o <= 1'b0;
                    end
                end
                default: begin
                    acc <= acc_next;
                    cnt <= cnt - 1'b1;
                    // Last iteration: MULHU/REMU take the upper half, MULU/DIVU the lower.
                    if (cnt == (SW+1)'(1)) begin
                        state          <= IDLE;
                        bus.valid_o    <= 1'b1;
                        bus.result_o   <= hi_sel ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];
                        bus.jump_now_o <= 1'b0;
                        bus.illegal_o  <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the core's combinational ALU.
- Registers its result behind a valid/ready handshake, adds rotate, and adds iterative unsigned multiply, multiply-high, divide and remainder.
- Sits between decode/regfile read and writeback. It has one operation in flight at a time and supports a kill for squashed instructions.

Parameters:
- WIDTH, 32: datapath width. Must be a power of two, >= 8. Shift amount field SW = $clog2(WIDTH).
- MUL_EN, 1: 1 = MULU/MULHU/DIVU/REMU implemented; 0 = those codes are treated as illegal.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- n_reset  in  1  synchronous active-low reset
- valid_i  in  1  operation request
- ready_o  out  1  block can accept a request this cycle
- op_i  in  5  operation code (table below)
- rd_i  in  WIDTH  operand A
- rs_i  in  WIDTH  operand B
- kill_i  in  1  abort in-flight op and drop any pending result
- valid_o  out  1  result registers hold a valid result
- ready_i  in  1  consumer takes result this cycle
- result_o  out  WIDTH  result
- jump_now_o  out  1  branch condition true
- illegal_o  out  1  op code unsupported; qualified by valid_o

Behaviour:
- Op codes:
  - 0 ADDU a+b; 1 SUBU a-b (both mod 2^WIDTH)
  - 2 SLLV a<<b[SW-1:0]; 3 SRAV arithmetic >>; 4 SRLV logical >>
  - 5 AND; 6 OR; 7 NOR; 10 XOR
  - 8 SLT signed a<b -> 1 else 0; 9 SLTU unsigned a<b -> 1 else 0
  - 11 ROTL rotate a left by b[SW-1:0]; amount 0 returns a unchanged
  - 12 MULU low WIDTH bits of a*b; 13 MULHU high WIDTH bits of a*b
  - 14 DIVU a/b; 15 REMU a%b
  - 16 BEQZ a==0; 17 BNEQZ a!=0; 18 BGTZ signed a>0; 19 BLTZ signed a<0
  - 20-31 illegal
- For branch ops (16-19): result_o = 0; jump_now_o = the condition.
- For all other ops: jump_now_o = 0.
- Illegal op (or codes 12-15 when MUL_EN=0): result 0, jump 0, illegal_o=1, completes with single-cycle latency.
- Divide by zero: DIVU returns all ones; REMU returns a. No exception is raised.
- FSM states: IDLE, MUL, DIV.
- ready_o = (state==IDLE) && (!valid_o || ready_i) && n_reset. It is combinational from state/valid_o/ready_i.
- Accept occurs when valid_i && ready_o at rising edge T. Operands and op are captured.
- Single-cycle ops: result registers load at T; valid_o=1 from T+1.
- MUL (12/13):
  - Shift-add, one bit per cycle, WIDTH iterations, 2*WIDTH-bit accumulator.
  - State is MUL for cycles T+1..T+WIDTH; valid_o=1 at T+WIDTH+1.
- DIV (14/15):
  - Restoring divide, one quotient bit per cycle, same WIDTH-cycle timing.
  - Divide-by-zero still takes WIDTH cycles.
- Iteration counter is SW+1 bits, loaded with WIDTH on entry. The FSM returns to IDLE and loads the result when the count reaches 0.
- Result hold: valid_o, result_o, jump_now_o and illegal_o stay stable while valid_o && !ready_i.
- Handshake completion: valid_o && ready_i clears valid_o next cycle unless a new single-cycle op is accepted in the same cycle. In that back-to-back case valid_o stays 1 with the new result, giving a throughput of 1 op/cycle.
- Busy: ready_o=0 throughout MUL/DIV. valid_i is ignored while busy.
- kill_i:
  - On the rising edge with kill_i=1: state goes to IDLE, valid_o goes to 0, and the iterative datapath is discarded.
  - kill_i has priority over an accept in the same cycle; the request is dropped.
  - ready_o is not gated by kill_i.
- Reset (n_reset=0 at edge):
  - State IDLE; valid_o=0, result_o=0, jump_now_o=0, illegal_o=0; counter cleared.
  - An in-flight op is discarded.
  - ready_o=0 while n_reset is low.
- Outputs when valid_o=0: result_o, jump_now_o and illegal_o hold their last values. Consumers must qualify them with valid_o.

Test Plan:
1. WIDTH=32, ready_i=1, back-to-back ADDU(0xFFFFFFFF,1), SLT(0xFFFFFFFF,1), ROTL(0x80000001,0), ROTL(0x80000001,4):
   - results 0x0, 0x1, 0x80000001, 0x00000018 on consecutive cycles starting T+1
   - valid_o held 1 for 4 cycles; ready_o never drops.
2. MULU(0xFFFF,0x10001) then MULHU(0xFFFFFFFF,0xFFFFFFFF):
   - 0xFFFFFFFF valid exactly 33 cycles after accept; second result 0xFFFFFFFE.
   - ready_o=0 for 32 cycles each.
3. DIVU(100,7) -> 14; REMU(100,7) -> 2; DIVU(5,0) -> 0xFFFFFFFF; REMU(5,0) -> 5; each with 33-cycle latency.
4. Backpressure: ready_i=0 after BLTZ(0x80000000):
   - valid_o=1, jump_now_o=1, result 0 held stable for 10 cycles; ready_o=0 throughout.
   - With ready_i=1, valid_o drops the next cycle.
5. kill_i asserted 10 cycles into DIVU: next cycle state IDLE, ready_o=1, valid_o never asserts. Repeat with n_reset=0 mid-MULU: same outcome plus all outputs 0.
6. MUL_EN=0, WIDTH=16, op 12 and op 25 -> single-cycle, illegal_o=1, result 0. SRAV(0x8000,15) -> 0xFFFF.
